// File: rtl/regfile_write_sequencer.sv
// Write-port controller for the 32x32 register file: zeroing sweep after reset or on
// demand, otherwise round-robin arbitration between core writeback (A) and debug/load (B).
module regfile_write_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_s;
    logic                last_grant_r, last_grant_s;   // 1'b0 = A, 1'b1 = B
    logic                wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0]   wr_data_r, wr_data_s;
    logic                grant_a_s, grant_b_s;
    logic                a_ready_s, b_ready_s, busy_s;

    // Round-robin choice: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_a_s = a_valid && (!b_valid || (last_grant_r == 1'b1));
        grant_b_s = b_valid && (!a_valid || (last_grant_r == 1'b0));
    end

    // Next-state, handshake and register-file write decode.
    always_comb begin
        state_s      = state_r;
        clr_cnt_s    = clr_cnt_r;
        last_grant_s = last_grant_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        a_ready_s    = 1'b0;
        b_ready_s    = 1'b0;
        busy_s       = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                busy_s    = 1'b1;
                wr_en_s   = 1'b1;
                wr_addr_s = clr_cnt_r;
                wr_data_s = DATA_ZERO;
                if (clr_cnt_r == ADDR_LAST) begin
                    state_s   = ST_RUN;
                    clr_cnt_s = ADDR_ZERO;
                end else begin
                    clr_cnt_s = clr_cnt_r + ADDR_ONE;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_s = ST_CLEAR;
                end else if (grant_a_s) begin
                    a_ready_s    = 1'b1;
                    last_grant_s = 1'b0;
                    wr_addr_s    = a_addr;
                    wr_data_s    = a_data;
                    wr_en_s      = (a_addr != ADDR_ZERO);  // x0 stays hard-wired zero
                end else if (grant_b_s) begin
                    b_ready_s    = 1'b1;
                    last_grant_s = 1'b1;
                    wr_addr_s    = b_addr;
                    wr_data_s    = b_data;
                    wr_en_s      = (b_addr != ADDR_ZERO);
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_cnt_s = ADDR_ZERO;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= ADDR_ZERO;
            last_grant_r <= 1'b1;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= ADDR_ZERO;
            wr_data_r    <= DATA_ZERO;
        end else begin
            state_r      <= state_s;
            clr_cnt_r    <= clr_cnt_s;
            last_grant_r <= last_grant_s;
            wr_en_r      <= wr_en_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
        end
    end

    assign busy       = busy_s;
    assign a_ready    = a_ready_s;
    assign b_ready    = b_ready_s;
    assign rf_wr_en   = wr_en_r;
    assign rf_wr_addr = wr_addr_r;
    assign rf_wr_data = wr_data_r;

endmodule
